ex_multi_issue: RTL
===================

EX_MULTI_ISSUE -- requirements
Module: ex_multi_issue

Interface
REQ-001 The block SHALL take parameter LANES, default 2, as the issue width (1..4).
REQ-002 The block SHALL take parameter XLEN, default 32, as the datapath width.
REQ-003 The block SHALL use a single clock and an asynchronous, active-high reset.
REQ-004 The block SHALL derive FW = clog2(2*LANES+1), the forwarding select width.
REQ-005 The block SHALL provide these ports; lane k occupies bits [k*W +: W] of every flat bus, and lane 0 is the oldest.
- clk  in  1  clock
- rst  in  1  asynchronous reset, active high
- stall  in  1  hold all EX/MA registers
- rr_valid  in  LANES  lane holds a real instruction
- rr_rdata1, rr_rdata2  in  LANES*XLEN  register-read operands
- rr_fwd1, rr_fwd2  in  LANES*FW  forwarding selects
- wb_data  in  LANES*XLEN  write-back data per lane
- rr_pc, rr_imm, rr_pred_pc  in  LANES*XLEN  PC, immediate, predicted next PC
- rr_is_br, rr_is_jalr  in  LANES  conditional branch / JALR
- rr_dst  in  LANES*5  destination register
- rr_we  in  LANES  register write enable
- alu_result  in  LANES*XLEN  result from the external per-lane ALU
- alu_br_taken  in  LANES*2  0 none, 1 pc+imm, 2 op1+imm
- fwd_op1, fwd_op2  out  LANES*XLEN  forwarded operands to the ALUs
- ex_result, ma_result  out  LANES*XLEN  EX/MA stage results
- ex_dst, ma_dst  out  LANES*5  destination registers
- ex_we, ma_we  out  LANES  write enables
- redirect  out  1  misprediction, combinational
- redirect_pc  out  XLEN  corrected PC
- mispredict_cnt  out  32  misprediction count (see Configuration)

Function
REQ-006 fwd_opN of lane k SHALL select by rr_fwdN: 0 = rr_rdataN; 1..LANES = ex_result of lane (sel-1); LANES+1..2*LANES = wb_data of lane (sel-LANES-1); any other value = rr_rdataN.
REQ-007 The target of lane k SHALL be, modulo 2^XLEN: pc+4 when taken=0 or 3, pc+imm when taken=1, and fwd_op1+imm when taken=2.
REQ-008 Lane k SHALL mispredict when rr_valid[k], (rr_is_br[k] or rr_is_jalr[k]), target != rr_pred_pc[k], and no older lane is redirecting or taken.
REQ-009 redirect SHALL be asserted when any lane mispredicts, and redirect_pc SHALL be the target of the lowest-index mispredicting lane.
REQ-010 When lane j has a nonzero alu_br_taken or mispredicts, all lanes k>j SHALL be squashed: they load we=0, dst=0 and result=0 into EX.
REQ-011 When stall=0, EX SHALL capture the RR lanes on each clk edge with we = rr_we AND rr_valid AND not squashed, and MA SHALL capture EX.
REQ-012 When stall=1, all EX and MA registers SHALL hold, and redirect SHALL be forced to 0.
REQ-013 The block SHALL have an EX-to-MA latency of exactly 1 cycle, and RR-to-ex_result latency of 1 cycle.
REQ-014 When two lanes mispredict in the same cycle, only the oldest SHALL count and redirect.

Reset
REQ-015 While rst=1, all ex_* and ma_* outputs and mispredict_cnt SHALL be 0, regardless of clk.
REQ-016 Deassertion of rst SHALL take effect without any extra cycle; the first post-reset edge with stall=0 SHALL capture normally.
REQ-017 If rst is asserted mid-stall, the block SHALL clear all state, and held data SHALL NOT reappear after rst falls.

Configuration
REQ-018 With MISPREDICT_CNT_EN defined, mispredict_cnt SHALL increment by 1 on each clk edge where redirect=1, saturating at 0xFFFFFFFF.
REQ-019 Without MISPREDICT_CNT_EN, mispredict_cnt SHALL be constant 0, and the block SHALL contain no counter flops.

Verification
REQ-020 LANES=2, lane1 rr_fwd1=1, ex_result lane0=0x1234 -> fwd_op1 lane1=0x1234.
REQ-021 Lane0 branch at pc 0x100, imm 0x20, taken=1, pred 0x104 -> redirect=1, redirect_pc=0x120; lane1 we=0 in EX next cycle.
REQ-022 Both lanes JALR mispredict (targets 0x200/0x300) -> redirect_pc=0x200; counter +1 only (MISPREDICT_CNT_EN defined).
REQ-023 stall=1 for 3 cycles with changing RR inputs -> ex_/ma_ outputs unchanged, redirect=0; the cycle after release captures current RR.
REQ-024 rst pulse during stall with ex_result=0xDEAD -> ex_result=0 immediately; after release with rr_valid=0, ma_we=0.
REQ-025 Counter forced to 0xFFFFFFFF plus a further mispredict -> it stays 0xFFFFFFFF; without the macro it reads 0.

Source files
------------

// File: rtl/ex_multi_issue.sv
// ex_multi_issue: execute stage of a multi-issue pipeline.
//   Forwards operands to the external per-lane ALUs, resolves branch/JALR
//   targets, detects mispredictions (oldest lane wins), squashes younger
//   lanes behind a taken or mispredicted lane, and registers EX and MA.
//
// Ports (lane k occupies [k*W +: W] of each flat bus, lane 0 is oldest):
//   clk, rst                   clock, asynchronous active-high reset
//   stall                      hold EX/MA registers, suppress redirect
//   rr_*                       register-read stage inputs per lane
//   wb_data                    write-back data per lane (forward source)
//   alu_result, alu_br_taken   external ALU result / branch outcome
//   fwd_op1, fwd_op2           forwarded operands to the ALUs
//   ex_*, ma_*                 EX and MA stage registers
//   redirect, redirect_pc      combinational misprediction redirect
//   mispredict_cnt             misprediction counter
//
// Optional feature: define MISPREDICT_CNT_EN to build a saturating
// misprediction counter; otherwise mispredict_cnt is constant 0.

module ex_multi_issue #(
    parameter int LANES = 2,
    parameter int XLEN  = 32,
    localparam int FW   = $clog2(2*LANES+1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic [LANES-1:0]      rr_valid,
    input  logic [LANES*XLEN-1:0] rr_rdata1,
    input  logic [LANES*XLEN-1:0] rr_rdata2,
    input  logic [LANES*FW-1:0]   rr_fwd1,
    input  logic [LANES*FW-1:0]   rr_fwd2,
    input  logic [LANES*XLEN-1:0] wb_data,
    input  logic [LANES*XLEN-1:0] rr_pc,
    input  logic [LANES*XLEN-1:0] rr_imm,
    input  logic [LANES*XLEN-1:0] rr_pred_pc,
    input  logic [LANES-1:0]      rr_is_br,
    input  logic [LANES-1:0]      rr_is_jalr,
    input  logic [LANES*5-1:0]    rr_dst,
    input  logic [LANES-1:0]      rr_we,
    input  logic [LANES*XLEN-1:0] alu_result,
    input  logic [LANES*2-1:0]    alu_br_taken,
    output logic [LANES*XLEN-1:0] fwd_op1,
    output logic [LANES*XLEN-1:0] fwd_op2,
    output logic [LANES*XLEN-1:0] ex_result,
    output logic [LANES*XLEN-1:0] ma_result,
    output logic [LANES*5-1:0]    ex_dst,
    output logic [LANES*5-1:0]    ma_dst,
    output logic [LANES-1:0]      ex_we,
    output logic [LANES-1:0]      ma_we,
    output logic                  redirect,
    output logic [XLEN-1:0]       redirect_pc,
    output logic [31:0]           mispredict_cnt
);

    // Select 0 and out-of-range selects fall back to the register-read value.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [FW-1:0]         sel,
        input logic [XLEN-1:0]       rdata,
        input logic [LANES*XLEN-1:0] ex_bus,
        input logic [LANES*XLEN-1:0] wb_bus
    );
        logic [XLEN-1:0] op;
        op = rdata;
        for (int j = 0; j < LANES; j++) begin
            if (sel == FW'(j + 1))
                op = ex_bus[j*XLEN +: XLEN];
            if (sel == FW'(LANES + 1 + j))
                op = wb_bus[j*XLEN +: XLEN];
        end
        return op;
    endfunction

    always_comb begin
        fwd_op1 = '0;
        fwd_op2 = '0;
        for (int k = 0; k < LANES; k++) begin
            fwd_op1[k*XLEN +: XLEN] = fwd_sel(rr_fwd1[k*FW +: FW],
                                              rr_rdata1[k*XLEN +: XLEN],
                                              ex_result, wb_data);
            fwd_op2[k*XLEN +: XLEN] = fwd_sel(rr_fwd2[k*FW +: FW],
                                              rr_rdata2[k*XLEN +: XLEN],
                                              ex_result, wb_data);
        end
    end

    logic [LANES-1:0] mispred;
    logic [LANES-1:0] squash;
    logic [XLEN-1:0]  mis_target;

    // Walk lanes oldest to youngest; once a lane is taken or mispredicts,
    // every younger lane is squashed and can no longer mispredict, so at
    // most one bit of mispred is ever set.
    always_comb begin
        logic            blk;
        logic [XLEN-1:0] tgt;
        logic [1:0]      tk;
        blk        = 1'b0;
        tgt        = '0;
        tk         = '0;
        mispred    = '0;
        squash     = '0;
        mis_target = '0;
        for (int k = 0; k < LANES; k++) begin
            tk = alu_br_taken[k*2 +: 2];
            case (tk)
                2'd1:    tgt = rr_pc[k*XLEN +: XLEN] + rr_imm[k*XLEN +: XLEN];
                2'd2:    tgt = fwd_op1[k*XLEN +: XLEN] + rr_imm[k*XLEN +: XLEN];
                default: tgt = rr_pc[k*XLEN +: XLEN] + XLEN'(4);
            endcase
            squash[k]  = blk;
            mispred[k] = rr_valid[k] && (rr_is_br[k] || rr_is_jalr[k]) &&
                         (tgt != rr_pred_pc[k*XLEN +: XLEN]) && !blk;
            if (mispred[k])
                mis_target = tgt;
            blk = blk || (tk != 2'd0) || mispred[k];
        end
    end

    assign redirect    = (|mispred) && !stall;
    assign redirect_pc = mis_target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_result <= '0;
            ex_dst    <= '0;
            ex_we     <= '0;
            ma_result <= '0;
            ma_dst    <= '0;
            ma_we     <= '0;
        end else if (!stall) begin
            for (int k = 0; k < LANES; k++) begin
                if (squash[k]) begin
                    ex_result[k*XLEN +: XLEN] <= '0;
                    ex_dst[k*5 +: 5]          <= '0;
                    ex_we[k]                  <= 1'b0;
                end else begin
                    ex_result[k*XLEN +: XLEN] <= alu_result[k*XLEN +: XLEN];
                    ex_dst[k*5 +: 5]          <= rr_dst[k*5 +: 5];
                    ex_we[k]                  <= rr_we[k] && rr_valid[k];
                end
            end
            ma_result <= ex_result;
            ma_dst    <= ex_dst;
            ma_we     <= ex_we;
        end
    end

`ifdef MISPREDICT_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (redirect && (cnt_q != 32'hFFFF_FFFF))
            cnt_q <= cnt_q + 32'd1;
    end

    assign mispredict_cnt = cnt_q;
`else
    assign mispredict_cnt = 32'd0;
`endif

endmodule
